serial_add_16b: RTL and testbench
=================================

Name: serial_add_16b

Overview:
- Multi-cycle operand sequencer that sits directly in front of the 4-bit ripple-carry adder `rca_4b`, which it instantiates.
- Each cycle it feeds one 4-bit slice of the registered operands, plus the registered carry, into `rca_4b`. It captures the slice sum and carry-out, so an N-bit add runs through a single 4-bit adder.
- Used where area matters more than latency, e.g. the multi-cycle address/offset path in the demo1 datapath.

Parameters:
- N, 16, operand/result width. Must be a multiple of 4 and at least 4.

Ports:
- clk, input, 1, system clock. All state changes on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, request a new add. Sampled only when busy=0.
- A, input, N, operand A. Captured on the edge that accepts start.
- B, input, N, operand B. Captured on the edge that accepts start.
- C_in, input, 1, carry-in. Captured on the edge that accepts start.
- S, output, N, registered sum of the last completed add.
- C_out, output, 1, registered carry-out of the last completed add.
- busy, output, 1, high while slices are being processed.
- done, output, 1, one-cycle pulse: S/C_out just updated.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named clk and rst.
- Reset values: state=IDLE, S=0, C_out=0, busy=0, done=0, slice counter=0, internal operand/partial/carry registers=0.
- FSM states: IDLE, RUN, DONE. busy=1 only in RUN; done=1 only in DONE. Both are decoded from registered state.
- IDLE:
  - start=1 at an edge: latch A, B, C_in into the operand/carry registers, clear the counter, go to RUN.
  - Otherwise stay in IDLE.
- RUN, slice k = counter:
  - `rca_4b` inputs: A_reg[4k+3:4k], B_reg[4k+3:4k], carry_reg.
  - On each edge: partial[4k+3:4k] <= slice sum; carry_reg <= slice carry-out; counter <= counter+1.
  - When k = N/4-1, that same edge loads S <= full partial result (including the final slice), loads C_out <= final carry, and moves to DONE.
- DONE (one cycle):
  - start=1: accepted as in IDLE, next state RUN. Back-to-back operation, no bubble.
  - Otherwise return to IDLE.
- Latency: for an accepted start at edge e0, RUN slices are processed at edges e1..e(N/4). done is high in the cycle after edge e(N/4). For N=16, busy is high after edges e0..e3 and done is high after e4.
- Throughput: one add per N/4+1 cycles.
- start while busy=1 is ignored; the operands are not re-sampled.
- Output hold: S and C_out hold the previous result through RUN, update atomically on the final-slice edge, and hold until the next completion or reset. Partial sums are never visible on S.
- Width rules:
  - Addition is unsigned modulo 2^N. C_out is the carry out of bit N-1.
  - The counter is ceil(log2(N/4)) bits wide, minimum 1. It never wraps past N/4-1.
- Reset during RUN or DONE: immediate abort to the reset values. No done pulse is produced for the aborted add. The next start after rst deasserts behaves normally.
- The `rca_4b` instance is the only adder in the block; no `+` operator is used on data.

Optional Feature:
- Macro: SERIAL_ADD_OFL_EN.
- Defined: adds output port Ofl (1 bit, reset 0).
  - Ofl = signed two's-complement overflow of the completed add: (A_reg[N-1]==B_reg[N-1]) && (final sum[N-1] != A_reg[N-1]).
  - Loaded on the same edge and with the same hold rules as S/C_out.
- Undefined: the Ofl port and its logic are absent; all other behaviour is identical.

Test Plan:
- A=0x1234, B=0x4321, C_in=0, start one cycle -> busy for 4 cycles, done once, S=0x5555, C_out=0. S stays at the old value until the done cycle.
- A=0xFFFF, B=0x0000, C_in=1 -> carry ripples through all 4 slices: S=0x0000, C_out=1.
- A=0x8000, B=0x8000, C_in=0 -> S=0x0000, C_out=1. With SERIAL_ADD_OFL_EN, Ofl=1. Then A=0x7FFF, B=0x0001 -> S=0x8000, C_out=0, Ofl=1.
- Start accepted with A=0x0001, B=0x0001; start held high during RUN with A=0xAAAA -> ignored; S=0x0002, and exactly one done pulse for that start.
- start asserted in the DONE cycle with A=0x00FF, B=0x0F01 -> accepted with no idle cycle. Second done exactly 5 cycles after the first, S=0x1000, C_out=0.
- rst pulsed after edge e2 of an add -> S=0, C_out=0, busy=0, done=0 immediately, and no done pulse. A following add of 0x0003+0x0004 gives S=0x0007.

Source files
------------

// File: rtl/serial_add_16b.sv
// serial_add_16b: N-bit adder run one 4-bit slice per cycle through a single rca_4b
//   Ports: clk, rst (async, active-high), start, A, B, C_in in;
//          S, C_out (registered result), busy (RUN), done (one-cycle pulse) out.
//   Optional: define SERIAL_ADD_OFL_EN to add output Ofl (signed overflow of the result).
`timescale 1ns/1ps
module rca_4b (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       c_o
);
   logic [4:0] c;
   always_comb begin
      c = '0;
      s_o = '0;
      c[0] = c_i;
      for (int i = 0; i < 4; i++) begin
         s_o[i] = a_i[i] ^ b_i[i] ^ c[i];
         c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
      end
      c_o = c[4];
   end
endmodule

module serial_add_16b #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         C_in,
   output logic [N-1:0] S,
   output logic         C_out,
   output logic         busy,
   output logic         done
`ifdef SERIAL_ADD_OFL_EN
   ,output logic        Ofl
`endif
);
   localparam int CW = (N / 4 > 1) ? $clog2(N / 4) : 1;
   localparam logic [CW-1:0] LAST = CW'(N / 4 - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q;
   logic [N-1:0] a_q, b_q, partial_q, full_d;
   logic [CW-1:0] cnt_q;
   logic carry_q, co_w;
   logic [3:0] sum_w;
   rca_4b u_rca (
      .a_i(a_q[4*cnt_q +: 4]),
      .b_i(b_q[4*cnt_q +: 4]),
      .c_i(carry_q),
      .s_o(sum_w),
      .c_o(co_w)
   );
   // Partial result with the current slice merged in; on the last slice this is the full sum.
   always_comb begin
      full_d = partial_q;
      full_d[4*cnt_q +: 4] = sum_w;
   end
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         partial_q <= '0;
         carry_q   <= 1'b0;
         cnt_q     <= '0;
         S         <= '0;
         C_out     <= 1'b0;
`ifdef SERIAL_ADD_OFL_EN
         Ofl       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               state_q <= start ? RUN : IDLE;
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  carry_q <= C_in;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               partial_q <= full_d;
               carry_q   <= co_w;
               cnt_q     <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  S       <= full_d;
                  C_out   <= co_w;
`ifdef SERIAL_ADD_OFL_EN
                  Ofl     <= (a_q[N-1] == b_q[N-1]) && (full_d[N-1] != a_q[N-1]);
`endif
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_16b.sv
// tb_serial_add_16b: directed-vector bench for serial_add_16b
`timescale 1ns/1ps
module tb_serial_add_16b;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [15:0] A = '0, B = '0;
   logic C_in = 1'b0;
   logic [15:0] S;
   logic C_out, busy, done;
   logic ofl;
   int n_cmp = 0, n_bad = 0;
   serial_add_16b dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .C_in(C_in),
      .S(S), .C_out(C_out), .busy(busy), .done(done)
`ifdef SERIAL_ADD_OFL_EN
      , .Ofl(ofl)
`endif
   );
`ifndef SERIAL_ADD_OFL_EN
   assign ofl = 1'b0;
`endif
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic [15:0] es, input logic ec, input logic eo);
      logic [15:0] old_s;
      old_s = S;
      A = a; B = b; C_in = ci; start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_busy"}, 16'(busy), 16'd1);
         chk({tag, "_hold"}, S, old_s);
         tick;
      end
      chk({tag, "_done"}, 16'(done), 16'd1);
      chk({tag, "_idle"}, 16'(busy), 16'd0);
      chk({tag, "_S"}, S, es);
      chk({tag, "_Cout"}, 16'(C_out), 16'(ec));
`ifdef SERIAL_ADD_OFL_EN
      chk({tag, "_Ofl"}, 16'(ofl), 16'(eo));
`else
      if (eo === 1'bx) chk({tag, "_Ofl"}, 16'(ofl), 16'd0);
`endif
      tick;
      chk({tag, "_pulse"}, 16'(done), 16'd0);
   endtask
   initial begin
      int cyc;
      #2;
      chk("rst_S", S, 16'h0000);
      chk("rst_Cout", 16'(C_out), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      tick;
      run_add("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_add("t2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
      run_add("t3", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      run_add("t4", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      // start held high during RUN with new operands must be ignored
      A = 16'h0001; B = 16'h0001; C_in = 1'b0; start = 1'b1;
      tick;
      A = 16'hAAAA;
      for (int i = 0; i < 3; i++) begin
         chk("ign_busy", 16'(busy), 16'd1);
         tick;
      end
      chk("ign_busy3", 16'(busy), 16'd1);
      start = 1'b0;
      tick;
      chk("ign_done", 16'(done), 16'd1);
      chk("ign_S", S, 16'h0002);
      tick;
      chk("ign_pulse", 16'(done), 16'd0);
      chk("ign_rerun", 16'(busy), 16'd0);
      // back-to-back: start in the DONE cycle
      A = 16'h1111; B = 16'h2222; start = 1'b1;
      tick;
      start = 1'b0;
      repeat (4) tick;
      chk("b2b_done1", 16'(done), 16'd1);
      chk("b2b_S1", S, 16'h3333);
      A = 16'h00FF; B = 16'h0F01; start = 1'b1;
      tick;
      start = 1'b0;
      chk("b2b_busy", 16'(busy), 16'd1);
      chk("b2b_S1hold", S, 16'h3333);
      cyc = 1;
      while (!done && cyc < 20) begin
         tick;
         cyc++;
      end
      chk("b2b_gap", 16'(cyc), 16'd5);
      chk("b2b_S2", S, 16'h1000);
      chk("b2b_Cout", 16'(C_out), 16'd0);
      tick;
      // reset mid-add aborts without a done pulse
      A = 16'h5555; B = 16'h1111; start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      tick;
      rst = 1'b1;
      #1;
      chk("ab_S", S, 16'h0000);
      chk("ab_Cout", 16'(C_out), 16'd0);
      chk("ab_busy", 16'(busy), 16'd0);
      chk("ab_done", 16'(done), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (done) cyc++;
      end
      chk("ab_nodone", 16'(cyc), 16'd0);
      run_add("t5", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
